// File: rtl/nhi_wide_mem_port.sv
// Multi-bank wide memory port: routes a TCDM-style request stream to interleaved superbanks,
// tracks fixed bank latency and buffers in-order responses. Optional counters: NHI_WIDE_MEM_PORT_PERF_EN.
module nhi_wide_mem_port #(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 512,
  parameter int unsigned NumBanks   = 2,
  parameter int unsigned MemLatency = 1,
  parameter int unsigned RespDepth  = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_i,
  output logic                              gnt_o,
  input  logic [AddrWidth-1:0]              addr_i,
  input  logic                              we_i,
  input  logic [DataWidth-1:0]              wdata_i,
  input  logic [DataWidth/8-1:0]            be_i,
  output logic                              rvalid_o,
  input  logic                              rready_i,
  output logic [DataWidth-1:0]              rdata_o,
  output logic [NumBanks-1:0]               bank_req_o,
  input  logic [NumBanks-1:0]               bank_gnt_i,
  output logic [NumBanks*AddrWidth-1:0]     bank_add_o,
  output logic [NumBanks-1:0]               bank_wen_o,
  output logic [NumBanks*DataWidth-1:0]     bank_wdata_o,
  output logic [NumBanks*DataWidth/8-1:0]   bank_be_o,
  input  logic [NumBanks*DataWidth-1:0]     bank_rdata_i,
  output logic [31:0]                       perf_req_o,
  output logic [31:0]                       perf_stall_o
);

  localparam int unsigned BeW  = DataWidth / 8;
  localparam int unsigned OffW = $clog2(BeW);
  localparam int unsigned SelW = (NumBanks > 1) ? $clog2(NumBanks) : 1;
  localparam int unsigned CntW = $clog2(RespDepth + 1);
  localparam int unsigned PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;

  logic [SelW-1:0]      sel;
  logic [CntW:0]        used;
  logic                 credit_ok;

  logic                 pipe_vld [MemLatency];
  logic [SelW-1:0]      pipe_sel [MemLatency];
  logic                 pipe_we  [MemLatency];
  logic                 tail_vld;
  logic [SelW-1:0]      tail_sel;
  logic                 tail_we;
  logic [CntW-1:0]      inflight_q;

  logic [DataWidth-1:0] bank_rdata [NumBanks];
  logic [DataWidth-1:0] fifo_mem   [RespDepth];
  logic [DataWidth-1:0] push_data;
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [CntW-1:0]      fifo_cnt_q;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;

  // ---------------- request side ----------------
  generate
    if (NumBanks > 1) begin : g_sel
      assign sel = addr_i[OffW +: SelW];
    end else begin : g_sel_single
      assign sel = '0;
    end
  endgenerate

  // Accepted-but-not-returned beats live either in the latency pipe or in the FIFO.
  assign used      = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
  assign credit_ok = used < (CntW+1)'(RespDepth);
  assign gnt_o     = req_i & credit_ok & bank_gnt_i[sel];

  always_comb begin
    bank_req_o = '0;
    if (req_i && credit_ok) begin
      bank_req_o[sel] = 1'b1;
    end
  end

  assign bank_add_o   = {NumBanks{addr_i}};
  assign bank_wen_o   = {NumBanks{we_i}};
  assign bank_wdata_o = {NumBanks{wdata_i}};
  assign bank_be_o    = {NumBanks{be_i}};

  // ---------------- latency pipe ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < MemLatency; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_sel[i] <= '0;
        pipe_we[i]  <= 1'b0;
      end
    end else begin
      pipe_vld[0] <= gnt_o;
      pipe_sel[0] <= sel;
      pipe_we[0]  <= we_i;
      for (int unsigned i = 1; i < MemLatency; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_sel[i] <= pipe_sel[i-1];
        pipe_we[i]  <= pipe_we[i-1];
      end
    end
  end

  assign tail_vld = pipe_vld[MemLatency-1];
  assign tail_sel = pipe_sel[MemLatency-1];
  assign tail_we  = pipe_we[MemLatency-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= '0;
    end else begin
      case ({gnt_o, tail_vld})
        2'b10:   inflight_q <= inflight_q + CntW'(1);
        2'b01:   inflight_q <= inflight_q - CntW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // ---------------- response FIFO ----------------
  always_comb begin
    for (int unsigned b = 0; b < NumBanks; b++) begin
      bank_rdata[b] = bank_rdata_i[b*DataWidth +: DataWidth];
    end
  end

  assign push_data = tail_we ? '0 : bank_rdata[tail_sel];
  assign fifo_push = tail_vld;
  assign fifo_pop  = rvalid_o & rready_i;
  assign fifo_full = fifo_cnt_q == CntW'(RespDepth);

  always_ff @(posedge clk_i) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(RespDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (fifo_pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(RespDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CntW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CntW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign rvalid_o = fifo_cnt_q != '0;
  assign rdata_o  = rvalid_o ? fifo_mem[rd_ptr_q] : '0;

  // Credit admission must make a push into a full, non-popping FIFO unreachable.
  assert property (@(posedge clk_i) disable iff (rst_i) !(fifo_push && fifo_full && !fifo_pop));

  // ---------------- performance counters ----------------
`ifdef NHI_WIDE_MEM_PORT_PERF_EN
  logic [31:0] perf_req_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_req_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (gnt_o && (perf_req_q != '1)) begin
        perf_req_q <= perf_req_q + 32'd1;
      end
      if (req_i && !credit_ok && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_req_o   = perf_req_q;
  assign perf_stall_o = perf_stall_q;
`else
  assign perf_req_o   = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_nhi_wide_mem_port.sv
// Randomized bench for nhi_wide_mem_port (2 banks x 512b, latency 1, depth 4) with a
// transaction-level reference: outstanding-beat credit plus an ordered response queue.
module tb_nhi_wide_mem_port;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 512;
  localparam int unsigned NB = 2;
  localparam int unsigned LAT = 1;
  localparam int unsigned DEPTH = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              req_i = 1'b0;
  logic              gnt_o;
  logic [AW-1:0]     addr_i = '0;
  logic              we_i = 1'b0;
  logic [DW-1:0]     wdata_i = '0;
  logic [DW/8-1:0]   be_i = '0;
  logic              rvalid_o;
  logic              rready_i = 1'b0;
  logic [DW-1:0]     rdata_o;
  logic [NB-1:0]     bank_req_o;
  logic [NB-1:0]     bank_gnt_i = '1;
  logic [NB*AW-1:0]  bank_add_o;
  logic [NB-1:0]     bank_wen_o;
  logic [NB*DW-1:0]  bank_wdata_o;
  logic [NB*DW/8-1:0] bank_be_o;
  logic [NB*DW-1:0]  bank_rdata_i;
  logic [31:0]       perf_req_o;
  logic [31:0]       perf_stall_o;

  nhi_wide_mem_port #(
    .AddrWidth(AW), .DataWidth(DW), .NumBanks(NB), .MemLatency(LAT), .RespDepth(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
    .wdata_i(wdata_i), .be_i(be_i), .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o),
    .bank_req_o(bank_req_o), .bank_gnt_i(bank_gnt_i), .bank_add_o(bank_add_o),
    .bank_wen_o(bank_wen_o), .bank_wdata_o(bank_wdata_o), .bank_be_o(bank_be_o),
    .bank_rdata_i(bank_rdata_i), .perf_req_o(perf_req_o), .perf_stall_o(perf_stall_o)
  );

  always #5 clk_i = ~clk_i;

  // Read data a bank returns for a given address: unique per bank and address.
  function automatic logic [DW-1:0] bank_data(input logic [AW-1:0] a, input int b);
    logic [DW-1:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = a ^ (k << 24) ^ (b == 1 ? 32'h00B1_0000 : 32'h00B0_0000);
    return d;
  endfunction

  // Bank stubs: fixed one-cycle latency, garbage on cycles without a granted request.
  logic [DW-1:0] bank_rd [NB];
  assign bank_rdata_i = {bank_rd[1], bank_rd[0]};
  always @(posedge clk_i) begin
    for (int b = 0; b < NB; b++) begin
      if (bank_req_o[b] && bank_gnt_i[b]) bank_rd[b] <= bank_data(bank_add_o[b*AW +: AW], b);
      else bank_rd[b] <= {16{$urandom()}};
    end
  end

  typedef struct { logic [DW-1:0] data; int unsigned ready; } resp_t;
  resp_t       q[$];
  int unsigned outstanding = 0;
  int unsigned cyc = 0;
  int unsigned m_perf_req = 0;
  int unsigned m_perf_stall = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic          e_credit, e_gnt, e_rvalid;
  logic [NB-1:0] e_breq;
  logic [DW-1:0] e_rdata;
  logic [31:0]   e_perf_req, e_perf_stall;

  task automatic drive(input bit rq, input logic [AW-1:0] a, input bit w, input bit rr, input logic [NB-1:0] bg);
    int sel;
    @(negedge clk_i);
    req_i = rq; addr_i = a; we_i = w; rready_i = rr; bank_gnt_i = bg;
    for (int k = 0; k < 16; k++) wdata_i[k*32 +: 32] = $urandom();
    be_i = {$urandom(), $urandom()};
    #1;
    sel      = int'(a[6]);
    e_credit = outstanding < DEPTH;
    e_gnt    = rq && e_credit && bg[sel];
    e_breq   = (rq && e_credit) ? NB'(1 << sel) : '0;
    e_rvalid = (q.size() > 0) && (q[0].ready <= cyc);
    e_rdata  = e_rvalid ? q[0].data : '0;
  endtask

  task automatic tick();
    resp_t r;
    if (e_rvalid && rready_i) begin
      void'(q.pop_front());
      outstanding--;
    end
    if (e_gnt) begin
      r.data  = we_i ? '0 : bank_data(addr_i, int'(addr_i[6]));
      r.ready = cyc + LAT + 1;
      q.push_back(r);
      outstanding++;
      m_perf_req++;
    end
    if (req_i && !e_credit) m_perf_stall++;
    cyc++;
  endtask

  task automatic model_reset();
    q.delete();
    outstanding  = 0;
    m_perf_req   = 0;
    m_perf_stall = 0;
  endtask

  task automatic perf_expect();
`ifdef NHI_WIDE_MEM_PORT_PERF_EN
    e_perf_req   = m_perf_req;
    e_perf_stall = m_perf_stall;
`else
    e_perf_req   = '0;
    e_perf_stall = '0;
`endif
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_i = 1'b1; req_i = 1'b1; addr_i = 32'h40; rready_i = 1'b1; bank_gnt_i = '1;
    #1;
    model_reset();
    vectors++; if (rvalid_o !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid: got %0b exp 0", rvalid_o); end
    vectors++; if (rdata_o !== '0) begin miscompares++; $display("FAIL rst_rdata: got %h exp 0", rdata_o); end
    vectors++; if (gnt_o !== 1'b1) begin miscompares++; $display("FAIL rst_gnt_follows_req: got %0b exp 1", gnt_o); end
    vectors++; if (bank_req_o !== 2'b10) begin miscompares++; $display("FAIL rst_bank_req: got %b exp 10", bank_req_o); end
    @(negedge clk_i);
    vectors++; if (rvalid_o !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid_held: got %0b exp 0", rvalid_o); end
    vectors++; if ({perf_req_o, perf_stall_o} !== 64'd0) begin miscompares++; $display("FAIL rst_perf: got %h/%h exp 0/0", perf_req_o, perf_stall_o); end
    req_i = 1'b0; rst_i = 1'b0;
  endtask

  // Idle cycles with rready high until the model has no pending responses.
  task automatic drain(input string tag);
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      drive(0, 32'h0, 0, 1, '1);
      vectors++; if (rvalid_o !== e_rvalid) begin miscompares++; $display("FAIL %s_rvalid: got %0b exp %0b", tag, rvalid_o, e_rvalid); end
      if (e_rvalid) begin
        vectors++; if (rdata_o !== e_rdata) begin miscompares++; $display("FAIL %s_rdata: got %h exp %h", tag, rdata_o[63:0], e_rdata[63:0]); end
      end
      tick();
    end
    vectors++; if (q.size() != 0) begin miscompares++; $display("FAIL %s_drain_timeout: got %0d pending exp 0", tag, q.size()); end
  endtask

  task automatic test_interleave();
    logic [AW-1:0] addrs [2];
    addrs[0] = 32'h00; addrs[1] = 32'h40;
    for (int i = 0; i < 2; i++) begin
      drive(1, addrs[i], 0, 1, '1);
      vectors++; if (gnt_o !== e_gnt) begin miscompares++; $display("FAIL il_gnt%0d: got %0b exp %0b", i, gnt_o, e_gnt); end
      vectors++; if (bank_req_o !== e_breq) begin miscompares++; $display("FAIL il_bank_req%0d: got %b exp %b", i, bank_req_o, e_breq); end
      vectors++; if (rvalid_o !== e_rvalid) begin miscompares++; $display("FAIL il_rvalid%0d: got %0b exp %0b", i, rvalid_o, e_rvalid); end
      tick();
    end
    drain("il");
  endtask

  task automatic test_backpressure();
    int unsigned nxt = 0;
    int unsigned gcnt = 0;
    for (int c = 0; c < 10; c++) begin
      drive(nxt < 6, 32'(nxt * 64), 0, 0, '1);
      vectors++; if (gnt_o !== e_gnt) begin miscompares++; $display("FAIL bp_gnt c%0d: got %0b exp %0b", c, gnt_o, e_gnt); end
      vectors++; if (bank_req_o !== e_breq) begin miscompares++; $display("FAIL bp_bank_req c%0d: got %b exp %b", c, bank_req_o, e_breq); end
      vectors++; if (rvalid_o !== e_rvalid) begin miscompares++; $display("FAIL bp_rvalid c%0d: got %0b exp %0b", c, rvalid_o, e_rvalid); end
      if (gnt_o === 1'b1) gcnt++;
      if (e_gnt) nxt++;
      tick();
    end
    vectors++; if (gcnt != 4) begin miscompares++; $display("FAIL bp_gnt_count: got %0d exp 4", gcnt); end
    perf_expect();
    @(negedge clk_i);
    vectors++; if (perf_stall_o !== e_perf_stall) begin miscompares++; $display("FAIL bp_perf_stall: got %0d exp %0d", perf_stall_o, e_perf_stall); end
    vectors++; if (perf_req_o !== e_perf_req) begin miscompares++; $display("FAIL bp_perf_req: got %0d exp %0d", perf_req_o, e_perf_req); end
    for (int c = 0; c < 40 && (nxt < 6 || q.size() > 0); c++) begin
      drive(nxt < 6, 32'(nxt * 64), 0, 1, '1);
      vectors++; if (gnt_o !== e_gnt) begin miscompares++; $display("FAIL bp_rel_gnt c%0d: got %0b exp %0b", c, gnt_o, e_gnt); end
      vectors++; if (rvalid_o !== e_rvalid) begin miscompares++; $display("FAIL bp_rel_rvalid c%0d: got %0b exp %0b", c, rvalid_o, e_rvalid); end
      if (e_rvalid) begin
        vectors++; if (rdata_o !== e_rdata) begin miscompares++; $display("FAIL bp_rel_rdata c%0d: got %h exp %h", c, rdata_o[63:0], e_rdata[63:0]); end
      end
      if (e_gnt) nxt++;
      tick();
    end
    vectors++; if (nxt != 6 || q.size() != 0) begin miscompares++; $display("FAIL bp_complete: got %0d beats %0d pending exp 6 beats 0 pending", nxt, q.size()); end
  endtask

  task automatic test_bank_stall();
    for (int c = 0; c < 4; c++) begin
      drive(1, 32'h40, 0, 1, (c < 3) ? 2'b01 : 2'b11);
      vectors++; if (gnt_o !== e_gnt) begin miscompares++; $display("FAIL bs_gnt c%0d: got %0b exp %0b", c, gnt_o, e_gnt); end
      vectors++; if (bank_req_o !== e_breq) begin miscompares++; $display("FAIL bs_bank_req c%0d: got %b exp %b", c, bank_req_o, e_breq); end
      vectors++; if (rvalid_o !== e_rvalid) begin miscompares++; $display("FAIL bs_rvalid c%0d: got %0b exp %0b", c, rvalid_o, e_rvalid); end
      tick();
    end
    drain("bs");
  endtask

  task automatic test_throughput();
    int unsigned gcnt = 0;
    for (int c = 0; c < 40; c++) begin
      drive(1, $urandom(), 0, 1, '1);
      vectors++; if (rvalid_o !== e_rvalid) begin miscompares++; $display("FAIL tp_rvalid c%0d: got %0b exp %0b", c, rvalid_o, e_rvalid); end
      if (e_rvalid) begin
        vectors++; if (rdata_o !== e_rdata) begin miscompares++; $display("FAIL tp_rdata c%0d: got %h exp %h", c, rdata_o[63:0], e_rdata[63:0]); end
      end
      if (gnt_o === 1'b1) gcnt++;
      tick();
    end
    vectors++; if (gcnt != 40) begin miscompares++; $display("FAIL tp_gnt_count: got %0d exp 40", gcnt); end
    drain("tp");
  endtask

  task automatic test_write();
    drive(1, 32'h80, 1, 1, '1);
    be_i = '1;
    #1;
    vectors++; if (gnt_o !== 1'b1) begin miscompares++; $display("FAIL wr_gnt: got %0b exp 1", gnt_o); end
    vectors++; if (bank_req_o !== 2'b01) begin miscompares++; $display("FAIL wr_bank_req: got %b exp 01", bank_req_o); end
    vectors++; if (bank_wen_o !== 2'b11) begin miscompares++; $display("FAIL wr_wen: got %b exp 11", bank_wen_o); end
    vectors++; if (bank_wdata_o !== {wdata_i, wdata_i}) begin miscompares++; $display("FAIL wr_wdata: got %h exp %h", bank_wdata_o[63:0], wdata_i[63:0]); end
    vectors++; if (bank_be_o !== '1) begin miscompares++; $display("FAIL wr_be: got %h exp all-ones", bank_be_o); end
    vectors++; if (bank_add_o !== {32'h80, 32'h80}) begin miscompares++; $display("FAIL wr_add: got %h exp 0000008000000080", bank_add_o); end
    tick();
    drain("wr");
  endtask

  task automatic test_reset_midburst();
    for (int c = 0; c < 3; c++) begin
      drive(1, 32'(c * 64), 0, 0, '1);
      vectors++; if (gnt_o !== e_gnt) begin miscompares++; $display("FAIL rm_gnt c%0d: got %0b exp %0b", c, gnt_o, e_gnt); end
      tick();
    end
    @(negedge clk_i);
    req_i = 1'b0; rst_i = 1'b1;
    #1;
    model_reset();
    vectors++; if (rvalid_o !== 1'b0) begin miscompares++; $display("FAIL rm_rvalid: got %0b exp 0", rvalid_o); end
    vectors++; if (rdata_o !== '0) begin miscompares++; $display("FAIL rm_rdata: got %h exp 0", rdata_o[63:0]); end
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(1, 32'h1C0, 0, 1, '1);
    vectors++; if (gnt_o !== e_gnt) begin miscompares++; $display("FAIL rm_post_gnt: got %0b exp %0b", gnt_o, e_gnt); end
    vectors++; if (rvalid_o !== 1'b0) begin miscompares++; $display("FAIL rm_post_rvalid: got %0b exp 0", rvalid_o); end
    tick();
    drain("rm");
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) < 6, NB'($urandom_range(0, 3)));
      vectors++; if (gnt_o !== e_gnt) begin miscompares++; $display("FAIL rnd_gnt c%0d: got %0b exp %0b", c, gnt_o, e_gnt); end
      vectors++; if (bank_req_o !== e_breq) begin miscompares++; $display("FAIL rnd_bank_req c%0d: got %b exp %b", c, bank_req_o, e_breq); end
      vectors++; if (rvalid_o !== e_rvalid) begin miscompares++; $display("FAIL rnd_rvalid c%0d: got %0b exp %0b", c, rvalid_o, e_rvalid); end
      if (e_rvalid) begin
        vectors++; if (rdata_o !== e_rdata) begin miscompares++; $display("FAIL rnd_rdata c%0d: got %h exp %h", c, rdata_o[63:0], e_rdata[63:0]); end
      end
      tick();
    end
    drain("rnd");
    perf_expect();
    @(negedge clk_i);
    vectors++; if (perf_req_o !== e_perf_req) begin miscompares++; $display("FAIL rnd_perf_req: got %0d exp %0d", perf_req_o, e_perf_req); end
    vectors++; if (perf_stall_o !== e_perf_stall) begin miscompares++; $display("FAIL rnd_perf_stall: got %0d exp %0d", perf_stall_o, e_perf_stall); end
  endtask

  initial begin
    test_reset();
    test_interleave();
    test_backpressure();
    test_bank_stall();
    test_throughput();
    test_write();
    test_reset_midburst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
